// File: rtl/source_pkg.sv
// Shared operand-read / execute types: the per-slot instruction bundle,
// the eight-lane issue bundle, lane numbering and the writeback snoop port.
package source_pkg;

  localparam int WORD_W = 32;
  localparam int PREG_W = 6;
  localparam int AREG_W = 5;
  localparam int CTL_W  = 8;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [PREG_W-1:0] preg_addr_t;
  typedef logic [AREG_W-1:0] areg_addr_t;

  typedef struct packed {
    logic       valid;
    logic [CTL_W-1:0] ctl;
    word_t      pc;
    word_t      imm;
    areg_addr_t src1;
    areg_addr_t src2;
    areg_addr_t dst;
    preg_addr_t psrc1;
    preg_addr_t psrc2;
    logic       forward_en1;
    logic       forward_en2;
    word_t      d1;
    word_t      d2;
  } source_instr_t;

  typedef struct packed {
    source_instr_t [3:0] alu_source;
    source_instr_t [1:0] mem_source;
    source_instr_t       branch_source;
    source_instr_t       mult_source;
  } source_data_t;

  localparam int NUM_SRC_LANES = 8;
  localparam int LANE_ALU0     = 0;
  localparam int LANE_ALU1     = 1;
  localparam int LANE_ALU2     = 2;
  localparam int LANE_ALU3     = 3;
  localparam int LANE_MEM0     = 4;
  localparam int LANE_MEM1     = 5;
  localparam int LANE_BRANCH   = 6;
  localparam int LANE_MULT     = 7;

  typedef struct packed {
    logic       valid;
    preg_addr_t dst;
    word_t      data;
  } wb_port_t;

endpackage

// File: rtl/operand_lane_fifo.sv
// One issue lane: 2-entry skid FIFO whose entries pick up pending operands
// from the writeback ports, both on entry and while they wait.
module operand_lane_fifo
  import source_pkg::*;
#(
  parameter int NUM_WB     = 4,
  parameter int LANE_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    flush,
  input  logic                    enq,
  input  source_instr_t           enq_slot,
  input  logic                    deq_ready,
  input  wb_port_t [NUM_WB-1:0]   wb,
  output logic                    full,
  output source_instr_t           head
);

  source_instr_t entry [2];
  logic          head_ptr;
  logic          tail_ptr;
  logic [1:0]    count;
  logic          issue;
  logic          push;
  logic          pop;

  // Lowest-numbered matching port wins: once a field is filled it stops matching.
  function automatic source_instr_t snoop(input source_instr_t e,
                                          input wb_port_t [NUM_WB-1:0] ports);
    source_instr_t r;
    r = e;
    for (int k = 0; k < NUM_WB; k++) begin
      if (ports[k].valid && r.forward_en1 && ports[k].dst == r.psrc1) begin
        r.d1          = ports[k].data;
        r.forward_en1 = 1'b0;
      end
      if (ports[k].valid && r.forward_en2 && ports[k].dst == r.psrc2) begin
        r.d2          = ports[k].data;
        r.forward_en2 = 1'b0;
      end
    end
    return r;
  endfunction

  assign issue = (count != 2'd0) && !entry[head_ptr].forward_en1
                                 && !entry[head_ptr].forward_en2;
  assign push  = enq && !flush;
  assign pop   = issue && deq_ready && !flush;
  assign full  = (count == 2'(LANE_DEPTH));

  always_comb begin
    head       = entry[head_ptr];
    head.valid = issue;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      entry[0] <= '0;
      entry[1] <= '0;
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      count    <= 2'd0;
    end else if (flush) begin
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      count    <= 2'd0;
    end else begin
      entry[0] <= snoop(entry[0], wb);
      entry[1] <= snoop(entry[1], wb);
      // Push is only granted below depth, so the tail slot is never the live head.
      if (push) begin
        entry[tail_ptr] <= snoop(enq_slot, wb);
        tail_ptr        <= ~tail_ptr;
      end
      if (pop) head_ptr <= ~head_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/exec_operand_buf.sv
// Receive-side operand buffer between operand read and the execution units:
// one snooping skid FIFO per issue slot, bundle accepted only if every target lane has room.
module exec_operand_buf
  import source_pkg::*;
#(
  parameter int NUM_WB     = 4,
  parameter int LANE_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic                      in_valid,
  input  source_data_t              in,
  output logic                      in_ready,
  output source_data_t              out,
  input  logic [NUM_SRC_LANES-1:0]  out_ready,
  input  logic [NUM_WB-1:0]         wb_valid,
  input  preg_addr_t [NUM_WB-1:0]   wb_dst,
  input  word_t [NUM_WB-1:0]        wb_data
);

  source_instr_t              lane_in  [NUM_SRC_LANES];
  source_instr_t              lane_out [NUM_SRC_LANES];
  logic [NUM_SRC_LANES-1:0]   lane_full;
  wb_port_t [NUM_WB-1:0]      wb;

  always_comb begin
    for (int k = 0; k < NUM_WB; k++) begin
      wb[k].valid = wb_valid[k];
      wb[k].dst   = wb_dst[k];
      wb[k].data  = wb_data[k];
    end
  end

  always_comb begin
    lane_in[LANE_ALU0]   = in.alu_source[0];
    lane_in[LANE_ALU1]   = in.alu_source[1];
    lane_in[LANE_ALU2]   = in.alu_source[2];
    lane_in[LANE_ALU3]   = in.alu_source[3];
    lane_in[LANE_MEM0]   = in.mem_source[0];
    lane_in[LANE_MEM1]   = in.mem_source[1];
    lane_in[LANE_BRANCH] = in.branch_source;
    lane_in[LANE_MULT]   = in.mult_source;
  end

  // Registered counts only: out_ready must not gate acceptance.
  always_comb begin
    in_ready = !flush;
    for (int l = 0; l < NUM_SRC_LANES; l++) begin
      if (lane_in[l].valid && lane_full[l]) in_ready = 1'b0;
    end
  end

  for (genvar l = 0; l < NUM_SRC_LANES; l++) begin : g_lane
    operand_lane_fifo #(
      .NUM_WB     (NUM_WB),
      .LANE_DEPTH (LANE_DEPTH)
    ) u_lane (
      .clk       (clk),
      .resetn    (resetn),
      .flush     (flush),
      .enq       (in_valid && in_ready && lane_in[l].valid),
      .enq_slot  (lane_in[l]),
      .deq_ready (out_ready[l]),
      .wb        (wb),
      .full      (lane_full[l]),
      .head      (lane_out[l])
    );
  end

  always_comb begin
    out               = '0;
    out.alu_source[0] = lane_out[LANE_ALU0];
    out.alu_source[1] = lane_out[LANE_ALU1];
    out.alu_source[2] = lane_out[LANE_ALU2];
    out.alu_source[3] = lane_out[LANE_ALU3];
    out.mem_source[0] = lane_out[LANE_MEM0];
    out.mem_source[1] = lane_out[LANE_MEM1];
    out.branch_source = lane_out[LANE_BRANCH];
    out.mult_source   = lane_out[LANE_MULT];
  end

endmodule

// File: tb/tb_exec_operand_buf.sv
// Bench for exec_operand_buf: directed scenarios plus randomized traffic
// compared against a queue-per-lane reference model.
module tb_exec_operand_buf;
  import source_pkg::*;

  localparam int NUM_WB = 4;

  logic                      clk = 1'b0;
  logic                      resetn;
  logic                      flush;
  logic                      in_valid;
  source_data_t              in_b;
  logic                      in_ready;
  source_data_t              out_b;
  logic [7:0]                out_ready;
  logic [NUM_WB-1:0]         wb_valid;
  preg_addr_t [NUM_WB-1:0]   wb_dst;
  word_t [NUM_WB-1:0]        wb_data;

  int errors = 0;
  int checks = 0;

  source_instr_t q [8][$];

  always #5 clk = ~clk;

  exec_operand_buf #(.NUM_WB(NUM_WB), .LANE_DEPTH(2)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in(in_b),
    .in_ready(in_ready), .out(out_b), .out_ready(out_ready),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data)
  );

  initial begin
    #2000000;
    $display("FAIL timeout reached before summary");
    $fatal(1, "timeout");
  end

  function automatic source_instr_t slot_of(source_data_t d, int l);
    case (l)
      0, 1, 2, 3: return d.alu_source[l[1:0]];
      4, 5:       return d.mem_source[l[0]];
      6:          return d.branch_source;
      default:    return d.mult_source;
    endcase
  endfunction

  function automatic source_data_t with_slot(source_data_t d, int l, source_instr_t s);
    case (l)
      0, 1, 2, 3: d.alu_source[l[1:0]] = s;
      4, 5:       d.mem_source[l[0]] = s;
      6:          d.branch_source = s;
      default:    d.mult_source = s;
    endcase
    return d;
  endfunction

  function automatic source_instr_t mk_slot(word_t pc, logic fe1, preg_addr_t p1,
                                            logic fe2, preg_addr_t p2, word_t d1, word_t d2);
    source_instr_t s;
    s = '0;
    s.valid = 1'b1; s.ctl = pc[7:0]; s.pc = pc; s.imm = ~pc;
    s.src1 = 5'd1; s.src2 = 5'd2; s.dst = 5'd3;
    s.forward_en1 = fe1; s.psrc1 = p1; s.forward_en2 = fe2; s.psrc2 = p2;
    s.d1 = d1; s.d2 = d2;
    return s;
  endfunction

  // Reference: a waiting operand takes the value of the lowest-numbered port naming it.
  function automatic source_instr_t resolve(source_instr_t e);
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid[k] && e.forward_en1 && wb_dst[k] == e.psrc1) begin
        e.d1 = wb_data[k]; e.forward_en1 = 1'b0;
      end
      if (wb_valid[k] && e.forward_en2 && wb_dst[k] == e.psrc2) begin
        e.d2 = wb_data[k]; e.forward_en2 = 1'b0;
      end
    end
    return e;
  endfunction

  function automatic bit m_ready();
    if (flush) return 1'b0;
    for (int l = 0; l < 8; l++)
      if (slot_of(in_b, l).valid && q[l].size() >= 2) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_issuable(int l);
    if (q[l].size() == 0) return 1'b0;
    return !q[l][0].forward_en1 && !q[l][0].forward_en2;
  endfunction

  function automatic void model_clear();
    for (int l = 0; l < 8; l++) q[l].delete();
  endfunction

  function automatic void model_adv();
    bit acc;
    bit pop;
    if (flush) begin
      model_clear();
      return;
    end
    acc = in_valid && m_ready();
    for (int l = 0; l < 8; l++) begin
      pop = m_issuable(l) && out_ready[l];
      for (int i = 0; i < q[l].size(); i++) q[l][i] = resolve(q[l][i]);
      if (pop) void'(q[l].pop_front());
      if (acc && slot_of(in_b, l).valid) q[l].push_back(resolve(slot_of(in_b, l)));
    end
  endfunction

  task automatic tick();
    model_adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; in_valid = 1'b0; in_b = '0; out_ready = '0;
    wb_valid = '0; wb_dst = '0; wb_data = '0;
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (out_b !== '0) begin
      errors++; $display("FAIL reset_out got %h want 0", out_b);
    end
    resetn = 1'b1;
    model_clear();
    @(posedge clk); #1;
  endtask

  task automatic test_plain_issue();
    source_instr_t o;
    in_b = with_slot('0, LANE_ALU0, mk_slot(32'h100, 0, 0, 0, 0, 32'h11, 32'h22));
    in_valid = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL plain_in_ready got %b want 1", in_ready);
    end
    tick(); idle(); #1;
    o = out_b.alu_source[0];
    checks++;
    if (o.valid !== 1'b1 || o.d1 !== 32'h11 || o.d2 !== 32'h22 || o.pc !== 32'h100) begin
      errors++; $display("FAIL plain_issue got v=%b d1=%h d2=%h pc=%h want 1/11/22/100",
                         o.valid, o.d1, o.d2, o.pc);
    end
    out_ready[0] = 1'b1;
    tick(); idle(); #1;
    checks++;
    if (out_b.alu_source[0].valid !== 1'b0) begin
      errors++; $display("FAIL plain_pop got %b want 0", out_b.alu_source[0].valid);
    end
  endtask

  task automatic test_snoop_fill();
    in_b = with_slot('0, LANE_MEM0, mk_slot(32'h200, 1, 6'd5, 0, 0, 32'h0, 32'h33));
    in_valid = 1'b1;
    tick(); idle();
    for (int c = 0; c < 3; c++) begin
      #1; checks++;
      if (out_b.mem_source[0].valid !== 1'b0) begin
        errors++; $display("FAIL snoop_wait cycle %0d got 1 want 0", c);
      end
      tick();
    end
    wb_valid[2] = 1'b1; wb_dst[2] = 6'd5; wb_data[2] = 32'hDEADBEEF; #1;
    checks++;
    if (out_b.mem_source[0].valid !== 1'b0) begin
      errors++; $display("FAIL snoop_same_cycle got 1 want 0");
    end
    tick(); idle(); #1;
    checks++;
    if (out_b.mem_source[0].valid !== 1'b1 || out_b.mem_source[0].d1 !== 32'hDEADBEEF
        || out_b.mem_source[0].d2 !== 32'h33) begin
      errors++; $display("FAIL snoop_fill got v=%b d1=%h d2=%h want 1/deadbeef/33",
                         out_b.mem_source[0].valid, out_b.mem_source[0].d1, out_b.mem_source[0].d2);
    end
    out_ready[LANE_MEM0] = 1'b1;
    tick(); idle();
  endtask

  task automatic test_bypass();
    in_b = with_slot('0, LANE_BRANCH, mk_slot(32'h600, 0, 0, 1, 6'd9, 32'h44, 32'h0));
    in_valid = 1'b1;
    wb_valid[0] = 1'b1; wb_dst[0] = 6'd9; wb_data[0] = 32'h7;
    tick(); idle(); #1;
    checks++;
    if (out_b.branch_source.valid !== 1'b1 || out_b.branch_source.d2 !== 32'h7
        || out_b.branch_source.forward_en2 !== 1'b0) begin
      errors++; $display("FAIL bypass got v=%b d2=%h fe2=%b want 1/7/0",
                         out_b.branch_source.valid, out_b.branch_source.d2, out_b.branch_source.forward_en2);
    end
    out_ready[LANE_BRANCH] = 1'b1;
    tick(); idle();
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1;
    in_b = with_slot('0, LANE_MULT, mk_slot(32'h701, 0, 0, 0, 0, 1, 2));
    tick();
    in_b = with_slot('0, LANE_MULT, mk_slot(32'h702, 0, 0, 0, 0, 3, 4));
    tick(); idle();
    in_b = with_slot('0, LANE_MULT, mk_slot(32'h703, 0, 0, 0, 0, 5, 6)); #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL full_lane_ready got %b want 0", in_ready);
    end
    out_ready[LANE_MULT] = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL full_lane_deq_ready got %b want 0", in_ready);
    end
    out_ready = '0;
    in_b = with_slot('0, LANE_ALU1, mk_slot(32'h110, 0, 0, 0, 0, 0, 0)); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL other_lane_ready got %b want 1", in_ready);
    end
    checks++;
    if (out_b.mult_source.pc !== 32'h701 || out_b.mult_source.valid !== 1'b1) begin
      errors++; $display("FAIL mult_head got pc=%h v=%b want 701/1",
                         out_b.mult_source.pc, out_b.mult_source.valid);
    end
    in_b = '0; out_ready[LANE_MULT] = 1'b1;
    tick(); #1;
    checks++;
    if (out_b.mult_source.pc !== 32'h702 || out_b.mult_source.valid !== 1'b1) begin
      errors++; $display("FAIL mult_second got pc=%h v=%b want 702/1",
                         out_b.mult_source.pc, out_b.mult_source.valid);
    end
    tick(); idle();
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    in_b = with_slot('0, LANE_ALU0, mk_slot(32'h501, 1, 6'd3, 0, 0, 0, 0));
    tick();
    in_b = with_slot('0, LANE_ALU0, mk_slot(32'h502, 0, 0, 0, 0, 0, 0));
    tick(); idle();
    out_ready[0] = 1'b1;
    tick(); #1;
    checks++;
    if (out_b.alu_source[0].valid !== 1'b0 || out_b.alu_source[0].pc !== 32'h501) begin
      errors++; $display("FAIL head_block got v=%b pc=%h want 0/501",
                         out_b.alu_source[0].valid, out_b.alu_source[0].pc);
    end
    wb_valid[1] = 1'b1; wb_dst[1] = 6'd3; wb_data[1] = 32'h33;
    tick(); wb_valid = '0; #1;
    checks++;
    if (out_b.alu_source[0].valid !== 1'b1 || out_b.alu_source[0].d1 !== 32'h33) begin
      errors++; $display("FAIL head_release got v=%b d1=%h want 1/33",
                         out_b.alu_source[0].valid, out_b.alu_source[0].d1);
    end
    tick(); #1;
    checks++;
    if (out_b.alu_source[0].pc !== 32'h502 || out_b.alu_source[0].valid !== 1'b1) begin
      errors++; $display("FAIL head_next got pc=%h v=%b want 502/1",
                         out_b.alu_source[0].pc, out_b.alu_source[0].valid);
    end
    tick(); idle();
  endtask

  task automatic test_flush();
    in_valid = 1'b1;
    in_b = with_slot(with_slot('0, LANE_ALU2, mk_slot(32'h120, 0, 0, 0, 0, 0, 0)),
                     LANE_MEM1, mk_slot(32'h510, 1, 6'd2, 0, 0, 0, 0));
    tick(); idle();
    flush = 1'b1; in_valid = 1'b1; out_ready = '1;
    in_b = with_slot('0, LANE_ALU3, mk_slot(32'h130, 0, 0, 0, 0, 0, 0));
    wb_valid[0] = 1'b1; wb_dst[0] = 6'd2; #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_in_ready got %b want 0", in_ready);
    end
    tick(); idle(); #1;
    for (int l = 0; l < 8; l++) begin
      checks++;
      if (slot_of(out_b, l).valid !== 1'b0) begin
        errors++; $display("FAIL flush_valid lane %0d got 1 want 0", l);
      end
    end
  endtask

  task automatic test_port_priority();
    in_valid = 1'b1;
    in_b = with_slot('0, LANE_ALU1, mk_slot(32'h111, 1, 6'd4, 0, 0, 0, 32'h5));
    tick(); idle();
    wb_valid = 4'b1011; wb_dst[0] = 6'd6; wb_data[0] = 32'hC;
    wb_dst[1] = 6'd4; wb_data[1] = 32'hA; wb_dst[3] = 6'd4; wb_data[3] = 32'hB;
    tick(); idle(); #1;
    checks++;
    if (out_b.alu_source[1].valid !== 1'b1 || out_b.alu_source[1].d1 !== 32'hA) begin
      errors++; $display("FAIL port_priority got v=%b d1=%h want 1/a",
                         out_b.alu_source[1].valid, out_b.alu_source[1].d1);
    end
    out_ready[LANE_ALU1] = 1'b1;
    tick(); idle();
  endtask

  function automatic source_instr_t rand_slot();
    source_instr_t s;
    s = '0;
    s.valid = $urandom_range(0, 1);
    s.ctl = 8'($urandom); s.pc = $urandom; s.imm = $urandom;
    s.src1 = 5'($urandom); s.src2 = 5'($urandom); s.dst = 5'($urandom);
    s.forward_en1 = ($urandom_range(0, 2) == 0); s.psrc1 = 6'($urandom_range(0, 7));
    s.forward_en2 = ($urandom_range(0, 2) == 0); s.psrc2 = 6'($urandom_range(0, 7));
    s.d1 = $urandom; s.d2 = $urandom;
    return s;
  endfunction

  task automatic test_random();
    source_instr_t exp;
    for (int c = 0; c < 400; c++) begin
      in_valid = $urandom_range(0, 1);
      for (int l = 0; l < 8; l++) in_b = with_slot(in_b, l, rand_slot());
      out_ready = 8'($urandom);
      flush = ($urandom_range(0, 29) == 0);
      for (int k = 0; k < NUM_WB; k++) begin
        wb_valid[k] = ($urandom_range(0, 2) == 0);
        wb_dst[k] = 6'($urandom_range(0, 7));
        wb_data[k] = $urandom;
      end
      #1;
      checks++;
      if (in_ready !== m_ready()) begin
        errors++; $display("FAIL rand_in_ready cycle %0d got %b want %b", c, in_ready, m_ready());
      end
      for (int l = 0; l < 8; l++) begin
        checks++;
        if (q[l].size() == 0) begin
          if (slot_of(out_b, l).valid !== 1'b0) begin
            errors++; $display("FAIL rand_empty cycle %0d lane %0d got valid 1 want 0", c, l);
          end
        end else begin
          exp = q[l][0];
          exp.valid = m_issuable(l);
          if (slot_of(out_b, l) !== exp) begin
            errors++; $display("FAIL rand_head cycle %0d lane %0d got %h want %h",
                               c, l, slot_of(out_b, l), exp);
          end
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    in_b = with_slot(with_slot('0, LANE_ALU0, mk_slot(32'h1, 0, 0, 0, 0, 0, 0)),
                     LANE_MULT, mk_slot(32'h7, 0, 0, 0, 0, 0, 0));
    tick(); tick(); idle();
    in_b = with_slot('0, LANE_MULT, mk_slot(32'h8, 0, 0, 0, 0, 0, 0)); #1;
    checks++;
    if (in_ready !== 1'b0 || out_b.mult_source.valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset got rdy=%b v=%b want 0/1", in_ready, out_b.mult_source.valid);
    end
    #1 resetn = 1'b0; #1;
    model_clear();
    checks++;
    if (in_ready !== 1'b1 || out_b.mult_source.valid !== 1'b0 || out_b.alu_source[0].valid !== 1'b0) begin
      errors++; $display("FAIL async_reset got rdy=%b mult=%b alu0=%b want 1/0/0",
                         in_ready, out_b.mult_source.valid, out_b.alu_source[0].valid);
    end
    @(posedge clk); #1 resetn = 1'b1;
    idle();
  endtask

  initial begin
    test_reset();
    test_plain_issue();
    test_snoop_fill();
    test_bypass();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_port_priority();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_operand_buf.md
# exec_operand_buf

Receive-side buffer for the operand-read stage output. It accepts a `source_data_t` bundle holding 4 ALU, 2 MEM, 1 branch and 1 mult `source_instr_t` slots. Each slot is held in a per-lane 2-entry skid FIFO. While a slot waits, the buffer snoops the writeback ports and fills any operand still marked `forward_en`. A slot is presented to its functional unit only when both operands are resolved. The block sits between the operand-read stage and the execution units.

## Interface
Parameters:
- `NUM_WB`, default 4: number of writeback snoop ports.
- `LANE_DEPTH`, default 2: entries per lane. It is fixed at 2; any other value is unsupported.

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `flush`  in  1: discard all buffered and incoming slots.
- `in_valid`  in  1: `in` bundle offered.
- `in`  in  `source_data_t`: per-slot `.valid` marks occupied lanes.
- `in_ready`  out  1: bundle accepted when `in_valid && in_ready`.
- `out`  out  `source_data_t`: head slot of each lane; `.valid` means issuable.
- `out_ready`  in  8: per-lane FU accept. Bits 0-3 are alu, 4-5 mem, 6 branch, 7 mult.
- `wb_valid`  in  `NUM_WB`: writeback result valid.
- `wb_dst`  in  `NUM_WB` x `preg_addr_t`: destination physical register.
- `wb_data`  in  `NUM_WB` x `word_t`: result value.

## Operation
- **Lane mapping.** Lane l maps to the flattened slot index: alu 0-3, mem 4-5 (`alu_source` first, then `mem_source`, `branch_source`, `mult_source`).
- **Acceptance.** `in_ready` = !flush && for every lane l with `in.<slot>.valid`: count[l] < 2.
  - It depends only on registered counts, never on `out_ready`.
- **Enqueue.** On acceptance, each valid slot is written at its lane tail and count[l] increments.
  - Lanes with `.valid`=0 are untouched.
- **Bypass capture on enqueue.** If the entering slot has `forward_en1` and some `wb_valid[k]` && `wb_dst[k]==psrc1` in the same cycle:
  - store `wb_data[k]` into `d1` and clear `forward_en1`.
  - Apply the same rule to `psrc2`/`d2`/`forward_en2`.
- **Snoop while buffered.** Each cycle, every buffered entry with `forward_enX`=1 compares `psrcX` against all valid wb ports.
  - On a match, `dX <= wb_data` and `forward_enX <= 0`.
  - Multiple matching ports: the lowest index k wins.
- **Issue.** `out.<slot>` = head entry.
  - `.valid` = count[l]>0 && !forward_en1 && !forward_en2.
  - Other fields always equal the head contents; when count=0 they hold the last-written values and are don't-care.
- **Dequeue.** On `out.valid && out_ready[l]`, the head pops and count[l] decrements.
  - Per-lane in-order: an unresolved head blocks its lane even if the second entry is resolved.
- **Flush.** All counts clear to 0 at the next edge.
  - Acceptance and dequeue in the flush cycle are suppressed.
  - Wb snoop results are discarded.
- **Unchanged fields.** `ctl`, `pc`, `imm`, `src1/2` and `dst` pass through unchanged.

## Timing
- **Reset.** While `resetn`=0: all counts 0, all `out.*.valid`=0, `in_ready`=1. Payload registers are reset to 0.
- **Enqueue-to-issue latency.** A slot enqueued at edge N with resolved operands shows `out.valid`=1 in cycle N+1.
  - There is no combinational path from `in` to `out`.
- **Writeback-to-issue latency.** A writeback at cycle N for a buffered entry makes the slot issuable in cycle N+1.
- **Full lane.** count=2 on a lane with an incoming valid slot forces `in_ready`=0, even if that lane dequeues in the same cycle.
- **Simultaneous enqueue and dequeue** at count 1: count stays 1 and the new entry becomes head+1.
- **Pointers.** Wrap-around uses a 1-bit head and a 1-bit tail pointer per lane, modulo 2.
- **Reset mid-operation.** The asynchronous clear drops all entries immediately.
  - `in_ready` returns to 1 combinationally once `flush`=0.

## Structure
- **`source_pkg` additions:**
  - `NUM_SRC_LANES`=8.
  - Lane index constants `LANE_ALU0`..`LANE_MULT`.
  - `wb_port_t` struct {valid, dst, data}.
- **Sub-module `operand_lane_fifo`:** one lane. It holds the 2-entry storage, count, pointers, enqueue bypass and wb snoop.
  - Eight instances are generated here.
  - The top level contains only the `in_ready` reduction and the struct flatten/unflatten.

## Test plan
- **Reset and plain issue:** reset, then enqueue a bundle with alu0 valid, forward_en=0, d1=0x11, d2=0x22. Required: `out.alu_source[0].valid`=1 next cycle with d1/d2 unchanged, and after `out_ready[0]` count returns to 0.
- **Snoop fill:** mem0 with forward_en1=1, psrc1=5 waits 3 cycles with `out.valid`=0. Then wb port 2 sends dst=5, data=0xDEADBEEF. Required: next cycle `out.valid`=1 and d1=0xDEADBEEF.
- **Same-cycle bypass:** enqueue branch slot with forward_en2=1, psrc2=9 while wb0 sends dst=9, data=0x7. Required: issuable next cycle with d2=0x7.
- **Backpressure:** hold `out_ready[7]`=0 and enqueue 2 mult slots. Required: `in_ready`=0 for a bundle containing mult, `in_ready`=1 for a bundle without mult, and the head stays the first slot (head-blocking order).
- **Flush:** with 2 lanes holding entries, assert flush concurrently with `in_valid`. Required: next cycle all `out.valid`=0, counts 0, and the concurrent bundle is not stored.
- **Port priority:** wb1 and wb3 both target dst=4 with data 0xA and 0xB. Required: the buffered entry takes 0xA.
